sccb_reg_sequencer: RTL

- Parametrised camera register-init sequencer.
- Walks a table of {reg_addr, value} entries held in an external synchronous ROM (BRAM loaded from a .mem file).
- For each entry, issues a 3-byte SCCB/I2C write (device address, register, value) through the byte-level i2c engine.
- Supports delay entries, an end marker, per-entry NACK retry, and a completion/error status for the camera top level and the debug LEDs.

---
 rtl/sccb_reg_sequencer_if.sv | 25 ++
 rtl/sccb_reg_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_sequencer_if.sv
// Sequencer-side bus: synchronous register-table ROM plus the byte-level i2c engine command port.
// master = sequencer, slave = ROM/engine side.
interface sccb_reg_sequencer_if #(
  parameter int LEN = 7
);
  logic            o_rom_rden;
  logic [LEN-1:0]  o_rom_addr;
  logic [15:0]     i_rom_data;
  logic            o_byte_valid;
  logic [7:0]      o_byte;
  logic            o_byte_first;
  logic            o_byte_last;
  logic            i_byte_done;
  logic            i_byte_nack;

  modport master (
    output o_rom_rden, o_rom_addr, o_byte_valid, o_byte, o_byte_first, o_byte_last,
    input  i_rom_data, i_byte_done, i_byte_nack
  );

  modport slave (
    input  o_rom_rden, o_rom_addr, o_byte_valid, o_byte, o_byte_first, o_byte_last,
    output i_rom_data, i_byte_done, i_byte_nack
  );
endinterface

// File: rtl/sccb_reg_sequencer.sv
// Camera register-init sequencer: walks a {reg,val} ROM table and issues 3-byte SCCB writes with delay, end-marker and NACK-retry support.
// One byte command outstanding at a time; the next byte is only issued after i_byte_done.
module sccb_reg_sequencer #(
  parameter int         DEPTH       = 77,
  parameter int         LEN         = $clog2(DEPTH),
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         ROM_LATENCY = 1,
  parameter int         DELAY_UNIT  = 50000,
  parameter int         MAX_RETRY   = 3,
  parameter int         INTER_GAP   = 500
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [LEN-1:0]    o_index,
  output logic [1:0]        o_retry_cnt,
  output logic [3:0]        o_state,
  sccb_reg_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ROM_REQ  = 4'd1,
    S_ROM_WAIT = 4'd2,
    S_DECODE   = 4'd3,
    S_SEND_DEV = 4'd4,
    S_SEND_REG = 4'd5,
    S_SEND_VAL = 4'd6,
    S_RETRY    = 4'd7,
    S_GAP      = 4'd8,
    S_DELAY    = 4'd9,
    S_NEXT     = 4'd10,
    S_DONE     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam int             DW       = 8 + $clog2(DELAY_UNIT + 1);
  localparam int             GW       = (INTER_GAP > 1) ? $clog2(INTER_GAP) : 1;
  localparam logic [DW-1:0]  DU       = DW'(DELAY_UNIT);
  localparam logic [GW-1:0]  GAP_END  = GW'(INTER_GAP - 1);
  localparam logic [2:0]     LAT_END  = 3'(ROM_LATENCY - 1);
  localparam logic [LEN-1:0] LAST_IDX = LEN'(DEPTH - 1);

  state_t          state;
  logic [2:0]      lat_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [7:0]      ent_reg;
  logic [7:0]      ent_val;
  logic            pend;
  logic            resend;

  assign o_state = state;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state            <= S_IDLE;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      o_index          <= '0;
      o_retry_cnt      <= '0;
      bus.o_rom_rden   <= 1'b0;
      bus.o_rom_addr   <= '0;
      bus.o_byte_valid <= 1'b0;
      bus.o_byte       <= '0;
      bus.o_byte_first <= 1'b0;
      bus.o_byte_last  <= 1'b0;
      lat_cnt          <= '0;
      gap_cnt          <= '0;
      dly_cnt          <= '0;
      ent_reg          <= '0;
      ent_val          <= '0;
      pend             <= 1'b0;
      resend           <= 1'b0;
    end else begin
      bus.o_rom_rden   <= 1'b0;
      bus.o_byte_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_index        <= '0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_busy         <= 1'b1;
            o_retry_cnt    <= '0;
            bus.o_rom_rden <= 1'b1;
            bus.o_rom_addr <= '0;
            state          <= S_ROM_REQ;
          end
        end
        S_ROM_REQ: begin
          lat_cnt <= '0;
          state   <= S_ROM_WAIT;
        end
        S_ROM_WAIT: begin
          if (lat_cnt == LAT_END) begin
            ent_reg <= bus.i_rom_data[15:8];
            ent_val <= bus.i_rom_data[7:0];
            state   <= S_DECODE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_DECODE: begin
          o_retry_cnt <= '0;
          if (ent_reg == 8'hFF) begin
            if (ent_val == 8'hFF) begin
              state <= S_DONE;
            end else if (ent_val == 8'h00) begin
              state <= S_NEXT;
            end else begin
              dly_cnt <= DW'(ent_val) * DU;
              state   <= S_DELAY;
            end
          end else begin
            state <= S_SEND_DEV;
          end
        end
        S_SEND_DEV, S_SEND_REG, S_SEND_VAL: begin
          // First cycle in a send state issues the byte; afterwards only i_byte_done matters.
          if (!pend) begin
            bus.o_byte_valid <= 1'b1;
            bus.o_byte       <= (state == S_SEND_DEV) ? DEV_ADDR :
                                (state == S_SEND_REG) ? ent_reg : ent_val;
            bus.o_byte_first <= (state == S_SEND_DEV);
            bus.o_byte_last  <= (state == S_SEND_VAL);
            pend             <= 1'b1;
          end else if (bus.i_byte_done) begin
            pend <= 1'b0;
            if (bus.i_byte_nack) begin
              state <= S_RETRY;
            end else if (state == S_SEND_DEV) begin
              state <= S_SEND_REG;
            end else if (state == S_SEND_REG) begin
              state <= S_SEND_VAL;
            end else begin
              resend  <= 1'b0;
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_RETRY: begin
          if (int'(o_retry_cnt) < MAX_RETRY) begin
            o_retry_cnt <= o_retry_cnt + 2'd1;
            resend      <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            state <= S_ERROR;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            state <= resend ? S_SEND_DEV : S_NEXT;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_DELAY: begin
          if (dly_cnt == '0) begin
            state <= S_NEXT;
          end else begin
            dly_cnt <= dly_cnt - DW'(1);
          end
        end
        S_NEXT: begin
          // The last table slot terminates the walk even without an end marker.
          if (o_index == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            o_index        <= o_index + LEN'(1);
            bus.o_rom_rden <= 1'b1;
            bus.o_rom_addr <= o_index + LEN'(1);
            state          <= S_ROM_REQ;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERROR: begin
          o_error <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
